// File: rtl/meter_time_core.sv
// Parking-meter time-keeping core: four-digit BCD remaining time with coin/preset
// requests, a deferred 1 Hz countdown and registered parked/low-time/expire flags.
module meter_time_core #(
    parameter int ADD_A        = 60,
    parameter int ADD_B        = 180,
    parameter int PRESET_SHORT = 10,
    parameter int PRESET_LONG  = 200,
    parameter int LOW_THRESH   = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       add_a,
    input  logic       add_b,
    input  logic       set_short,
    input  logic       set_long,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       parked,
    output logic       low_time,
    output logic       expire
);

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Per-digit carry; a carry out of the thousands digit saturates at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return c ? 16'h9999 : r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] a);
        logic [15:0] r;
        logic        b;
        if (a == 16'h0000) return a;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!b) begin
                r[4*i +: 4] = a[4*i +: 4];
            end else if (a[4*i +: 4] == 4'd0) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = a[4*i +: 4] - 4'd1;
                b = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
        for (int i = 3; i >= 0; i--) begin
            if (a[4*i +: 4] != b[4*i +: 4]) return a[4*i +: 4] < b[4*i +: 4];
        end
        return 1'b0;
    endfunction

    localparam logic [15:0] ADD_A_BCD  = to_bcd(ADD_A);
    localparam logic [15:0] ADD_B_BCD  = to_bcd(ADD_B);
    localparam logic [15:0] SHORT_BCD  = to_bcd(PRESET_SHORT);
    localparam logic [15:0] LONG_BCD   = to_bcd(PRESET_LONG);
    localparam logic [15:0] THRESH_BCD = to_bcd(LOW_THRESH);

    logic [15:0] digits_q, digits_d;
    logic        pend_q, pend_d;
    logic        parked_q, parked_d;
    logic        low_q, low_d;
    logic        expire_q, expire_d;

    // A tick seen during a set is discarded; during an add it stays pending.
    always_comb begin
        digits_d = digits_q;
        pend_d   = pend_q | tick_1hz;
        expire_d = 1'b0;
        if (set_long) begin
            digits_d = LONG_BCD;
            pend_d   = 1'b0;
        end else if (set_short) begin
            digits_d = SHORT_BCD;
            pend_d   = 1'b0;
        end else if (add_b) begin
            digits_d = bcd_add_sat(digits_q, ADD_B_BCD);
        end else if (add_a) begin
            digits_d = bcd_add_sat(digits_q, ADD_A_BCD);
        end else if (pend_q || tick_1hz) begin
            digits_d = bcd_dec(digits_q);
            pend_d   = 1'b0;
            expire_d = (digits_q == 16'h0001);
        end
        parked_d = (digits_d != 16'h0000);
        low_d    = parked_d && bcd_lt(digits_d, THRESH_BCD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= 16'h0000;
            pend_q   <= 1'b0;
            parked_q <= 1'b0;
            low_q    <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            digits_q <= digits_d;
            pend_q   <= pend_d;
            parked_q <= parked_d;
            low_q    <= low_d;
            expire_q <= expire_d;
        end
    end

    assign digit3   = digits_q[15:12];
    assign digit2   = digits_q[11:8];
    assign digit1   = digits_q[7:4];
    assign digit0   = digits_q[3:0];
    assign parked   = parked_q;
    assign low_time = low_q;
    assign expire   = expire_q;

endmodule

// File: tb/tb_meter_time_core.sv
// Directed bench for meter_time_core with default parameters (60/180/10/200/180).
module tb_meter_time_core;

    logic       clk = 1'b0;
    logic       rst_n, tick_1hz, add_a, add_b, set_short, set_long;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       parked, low_time, expire;

    int n_assert = 0;
    int n_fail   = 0;

    meter_time_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .add_a     (add_a),
        .add_b     (add_b),
        .set_short (set_short),
        .set_long  (set_long),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .parked    (parked),
        .low_time  (low_time),
        .expire    (expire)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        tick_1hz = 0; add_a = 0; add_b = 0; set_short = 0; set_long = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] d, input logic p,
                           input logic l, input logic e);
        chk({tag, ".digits"}, {digit3, digit2, digit1, digit0}, d);
        chk({tag, ".parked"}, {15'd0, parked}, {15'd0, p});
        chk({tag, ".low"}, {15'd0, low_time}, {15'd0, l});
        chk({tag, ".expire"}, {15'd0, expire}, {15'd0, e});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1; cycle(); tick_1hz = 0;
        end
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        cycle(); cycle();
        rst_n = 1;
        chk_all("reset", 16'h0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle();
        chk_all("idle", 16'h0000, 0, 0, 0);
        ticks(1);
        chk_all("tick_at_zero", 16'h0000, 0, 0, 0);
        cycle();
        chk_all("tick_at_zero_after", 16'h0000, 0, 0, 0);

        // Adds and multi-digit borrow
        add_a = 1; cycle(); add_a = 0;
        chk_all("add_a", 16'h0060, 1, 1, 0);
        add_b = 1; cycle(); add_b = 0;
        chk_all("add_b", 16'h0240, 1, 0, 0);
        ticks(1);
        chk_all("dec_0239", 16'h0239, 1, 0, 0);
        ticks(39);
        chk_all("dec_0200", 16'h0200, 1, 0, 0);
        ticks(1);
        chk_all("borrow_0199", 16'h0199, 1, 0, 0);
        ticks(19);
        chk_all("dec_0180", 16'h0180, 1, 0, 0);
        ticks(1);
        chk_all("low_rise_0179", 16'h0179, 1, 1, 0);

        // Saturation at 9999
        set_long = 1; cycle(); set_long = 0;
        chk_all("set_long", 16'h0200, 1, 0, 0);
        for (int i = 0; i < 54; i++) begin
            add_b = 1; cycle(); add_b = 0;
        end
        chk_all("add_b_x54", 16'h9920, 1, 0, 0);
        add_a = 1; cycle(); add_a = 0;
        chk_all("add_a_9980", 16'h9980, 1, 0, 0);
        add_b = 1; cycle(); add_b = 0;
        chk_all("add_b_sat", 16'h9999, 1, 0, 0);
        add_a = 1; cycle(); add_a = 0;
        chk_all("add_a_sat", 16'h9999, 1, 0, 0);

        // Countdown to expiry
        set_short = 1; cycle(); set_short = 0;
        chk_all("set_short", 16'h0010, 1, 1, 0);
        ticks(9);
        chk_all("dec_0001", 16'h0001, 1, 1, 0);
        ticks(1);
        chk_all("expire", 16'h0000, 0, 0, 1);
        cycle();
        chk_all("expire_one_cycle", 16'h0000, 0, 0, 0);

        // Tick deferred behind add
        set_long = 1; cycle(); set_long = 0;
        ticks(100);
        chk_all("at_0100", 16'h0100, 1, 1, 0);
        add_a = 1; tick_1hz = 1; cycle(); clear_in();
        chk_all("add_with_tick", 16'h0160, 1, 1, 0);
        cycle();
        chk_all("deferred_dec", 16'h0159, 1, 1, 0);
        cycle();
        chk_all("deferred_once", 16'h0159, 1, 1, 0);
        add_a = 1; tick_1hz = 1; cycle();
        chk_all("b2b_add1", 16'h0219, 1, 0, 0);
        cycle(); clear_in();
        chk_all("b2b_add2", 16'h0279, 1, 0, 0);
        cycle();
        chk_all("merged_dec", 16'h0278, 1, 0, 0);
        cycle();
        chk_all("merged_once", 16'h0278, 1, 0, 0);

        // Set discards coincident tick
        ticks(228);
        chk_all("at_0050", 16'h0050, 1, 1, 0);
        set_long = 1; add_b = 1; tick_1hz = 1; cycle(); clear_in();
        chk_all("set_priority", 16'h0200, 1, 0, 0);
        cycle();
        chk_all("tick_discarded", 16'h0200, 1, 0, 0);

        // Reset clears a pending tick
        add_a = 1; tick_1hz = 1; cycle(); clear_in();
        chk_all("pending_set", 16'h0260, 1, 0, 0);
        rst_n = 0; add_a = 1; cycle(); clear_in();
        chk_all("reset_mid", 16'h0000, 0, 0, 0);
        rst_n = 1;
        add_a = 1; cycle(); add_a = 0;
        chk_all("post_reset_add", 16'h0060, 1, 1, 0);
        cycle();
        chk_all("no_stale_dec", 16'h0060, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
